// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART receive path.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit per frame).
package uart_pkg;

  // Receive FSM state encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  // STATUS register bit positions
  localparam int unsigned STAT_RXV  = 0;
  localparam int unsigned STAT_OVR  = 1;
  localparam int unsigned STAT_FERR = 2;
  localparam int unsigned STAT_PERR = 3;

  // Default word addresses (addr[31:2]) shared with the transmit-side decode
  localparam logic [29:0] DEF_DATA_ADDR = 30'h2c000000;
  localparam logic [29:0] DEF_STAT_ADDR = 30'h2c000001;

  // STATUS payload, MSB first so bit positions match STAT_* above
  typedef struct packed {
    logic perr;
    logic ferr;
    logic ovr;
    logic rxv;
  } rx_status_t;

  // Widen the STATUS payload onto the 32-bit read bus
  function automatic logic [31:0] status_word(input rx_status_t s);
    return {28'b0, s};
  endfunction

endpackage

// File: rtl/uart_rx_mmio_if.sv
// CPU load-side bus of the UART receiver: strobe, word address, read data, irq.
interface uart_rx_mmio_if;
  logic        re;
  logic [29:0] addr;
  logic [31:0] rdata;
  logic        rx_irq;

  modport master (output re, output addr, input rdata, input rx_irq);
  modport slave  (input re, input addr, output rdata, output rx_irq);
endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous byte FIFO; a push into a full FIFO survives if a pop
// happens in the same cycle, otherwise it is dropped and flagged on drop_c.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full_c,
  output logic             empty_c,
  output logic [WIDTH-1:0] head_c,
  output logic             drop_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty_c = (count == '0);
  assign full_c  = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty_c;
  assign do_push = push & (~full_c | do_pop);
  assign drop_c  = push & ~do_push;
  assign head_c  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with 16x oversampling, byte FIFO and DATA/STATUS load registers.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit, sticky perr in STATUS bit3).
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 27,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [29:0] DATA_ADDR  = DEF_DATA_ADDR,
  parameter logic [29:0] STAT_ADDR  = DEF_STAT_ADDR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rxd,
  uart_rx_mmio_if.slave bus
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic          sync1;
  logic          rxs;
  logic [TW-1:0] tcnt;
  logic          tick_c;

  rx_state_e     state;
  rx_state_e     state_d;
  logic [3:0]    sc;
  logic [3:0]    sc_d;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_d;
  logic [7:0]    shreg;
  logic [7:0]    shreg_d;
  logic          push_q;
  logic          push_d;
  logic          ferr_set_c;

  logic          pre_re;
  logic          rd_edge_c;
  logic          pop_c;
  logic          stat_clr_c;
  logic          ovr;
  logic          ferr;
  logic          perr;

  logic          full_c;
  logic          empty_c;
  logic [7:0]    head_c;
  logic          drop_c;
  rx_status_t    status_c;

`ifdef UART_RX_PARITY_EN
  logic          par_bad;
  logic          par_bad_d;
  logic          perr_set_c;
`endif

  // Two-flop synchroniser on the asynchronous serial input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  // Free-running 1/16-bit tick divider
  assign tick_c = (tcnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= '0;
    else        tcnt <= tick_c ? '0 : tcnt + TW'(1);
  end

  // Receive FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sc      <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      push_q  <= 1'b0;
    end else begin
      state   <= state_d;
      sc      <= sc_d;
      bit_idx <= bit_d;
      shreg   <= shreg_d;
      push_q  <= push_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity verdict held from the parity sample until the stop sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_bad <= 1'b0;
    else        par_bad <= par_bad_d;
  end
`endif

  // Next-state and sample logic; samples land mid-bit at sc==15 (sc==7 for start)
  always_comb begin
    state_d    = state;
    sc_d       = sc;
    bit_d      = bit_idx;
    shreg_d    = shreg;
    push_d     = 1'b0;
    ferr_set_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad;
    perr_set_c = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!rxs) begin
          sc_d    = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick_c) begin
          if (sc == 4'd7) begin
            if (rxs) begin
              state_d = ST_IDLE;
            end else begin
              sc_d    = '0;
              bit_d   = '0;
              state_d = ST_DATA;
`ifdef UART_RX_PARITY_EN
              par_bad_d = 1'b0;
`endif
            end
          end else begin
            sc_d = sc + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          sc_d = sc + 4'd1;
          if (sc == 4'd15) begin
            shreg_d = {rxs, shreg[7:1]};
            bit_d   = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_c) begin
          sc_d = sc + 4'd1;
          if (sc == 4'd15) begin
            par_bad_d  = ^{shreg, rxs};
            perr_set_c = ^{shreg, rxs};
            state_d    = ST_STOP;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick_c) begin
          sc_d = sc + 4'd1;
          if (sc == 4'd15) begin
            if (rxs) begin
`ifdef UART_RX_PARITY_EN
              push_d = ~par_bad;
`else
              push_d = 1'b1;
`endif
              state_d = ST_IDLE;
            end else begin
              ferr_set_c = 1'b1;
              state_d    = ST_WAIT_HIGH;
            end
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Byte queue between the deserialiser and the CPU
  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_q),
    .din     (shreg),
    .pop     (pop_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .head_c  (head_c),
    .drop_c  (drop_c)
  );

  // Load strobe edge detect so a long strobe acts only once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_re <= 1'b0;
    else        pre_re <= bus.re;
  end

  assign rd_edge_c  = bus.re & ~pre_re;
  assign pop_c      = rd_edge_c & (bus.addr == DATA_ADDR) & ~empty_c;
  assign stat_clr_c = rd_edge_c & (bus.addr == STAT_ADDR);

  // Sticky error flags; a set in the clearing cycle wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
      perr <= 1'b0;
    end else begin
      ovr  <= drop_c     | (ovr  & ~stat_clr_c);
      ferr <= ferr_set_c | (ferr & ~stat_clr_c);
`ifdef UART_RX_PARITY_EN
      perr <= perr_set_c | (perr & ~stat_clr_c);
`else
      perr <= 1'b0;
`endif
    end
  end

  // Read mux, combinational from the address
  always_comb begin
    status_c.perr = perr;
    status_c.ferr = ferr;
    status_c.ovr  = ovr;
    status_c.rxv  = ~empty_c;
    bus.rdata     = '0;
    if (bus.addr == DATA_ADDR) begin
      if (!empty_c) bus.rdata = {24'b0, head_c};
    end else if (bus.addr == STAT_ADDR) begin
      bus.rdata = status_word(status_c);
    end
  end

  assign bus.rx_irq = ~empty_c;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio with a frame-level queue model and per-cycle compare.
`timescale 1ns/1ps
module tb_uart_rx_mmio;

  localparam int unsigned D     = 2;
  localparam int unsigned P     = 16 * D;
  localparam int unsigned DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NB = 9;
`else
  localparam int unsigned NB = 8;
`endif
  localparam logic [29:0] A_DATA  = 30'h2c000000;
  localparam logic [29:0] A_STAT  = 30'h2c000001;
  localparam logic [29:0] A_OTHER = 30'h2c000007;

  logic clk = 1'b0;
  logic rst_n;
  logic rxd;

  uart_rx_mmio_if bus();

  uart_rx_mmio #(
    .TICK_DIV   (D),
    .FIFO_DEPTH (DEPTH),
    .DATA_ADDR  (A_DATA),
    .STAT_ADDR  (A_STAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edge count since reset release: edge n leaves ecnt == n
  int unsigned ecnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  int          checks = 0;
  int          passed = 0;
  bit          settled = 1'b0;
  logic [7:0]  q[$];
  bit          m_ovr, m_ferr, m_perr;
  int unsigned frame_a;
  logic [31:0] got;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Expected read data for a given address from the model state
  function automatic logic [31:0] exp_rdata(input logic [29:0] a);
    if (a == A_DATA) return (q.size() != 0) ? {24'b0, q[0]} : 32'h0;
    if (a == A_STAT) return {28'b0, m_perr, m_ferr, m_ovr, q.size() != 0};
    return 32'h0;
  endfunction

  // Outcome of one complete frame on the model
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic pflip);
    if (pflip) m_perr = 1'b1;
    if (!stop) m_ferr = 1'b1;
    else if (!pflip) begin
      if (q.size() == DEPTH) m_ovr = 1'b1;
      else q.push_back(b);
    end
  endtask

  task automatic model_read(input logic [29:0] a);
    if (a == A_DATA && q.size() != 0) void'(q.pop_front());
    if (a == A_STAT) begin
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      m_perr = 1'b0;
    end
  endtask

  // Edge at which the FIFO accepts a frame whose start bit was driven after edge a
  function automatic int unsigned push_edge(input int unsigned a);
    int unsigned t1;
    t1 = ((a + 4 + D - 1) / D) * D;
    return t1 + 7 * D + 16 * D * (1 + NB) + 1;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pflip,
                            input logic idle);
    @(posedge clk); #1;
    frame_a = ecnt;
    rxd = 1'b0;
    repeat (P) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (P) @(posedge clk); #1;
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^b) ^ pflip;
    repeat (P) @(posedge clk); #1;
`endif
    rxd = stop;
    repeat (P) @(posedge clk); #1;
    rxd = idle;
  endtask

  task automatic frame(input logic [7:0] b, input logic stop, input logic pflip, input logic idle);
    settled = 1'b0;
    send_frame(b, stop, pflip, idle);
    model_frame(b, stop, pflip);
    settled = 1'b1;
  endtask

  task automatic do_read(input logic [29:0] a, input int hold, output logic [31:0] val);
    @(posedge clk); #1;
    bus.addr = a;
    bus.re   = 1'b1;
    @(negedge clk);
    val = bus.rdata;
    @(posedge clk);
    model_read(a);
    repeat (hold - 1) @(posedge clk);
    #1 bus.re = 1'b0;
  endtask

  // Continuous comparison against the model whenever no frame is in flight
  always @(negedge clk) begin
    if (settled && rst_n) begin
      chk("rx_irq", 32'(bus.rx_irq), 32'(q.size() != 0));
      chk("rdata", bus.rdata, exp_rdata(bus.addr));
    end
  end

  initial begin
    rst_n    = 1'b0;
    rxd      = 1'b1;
    bus.re   = 1'b0;
    bus.addr = A_STAT;
    m_ovr    = 1'b0;
    m_ferr   = 1'b0;
    m_perr   = 1'b0;

    // Reset state
    #22;
    chk("reset_irq", 32'(bus.rx_irq), 32'h0);
    chk("reset_stat", bus.rdata, 32'h0);
    bus.addr = A_DATA;
    #1;
    chk("reset_data", bus.rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    settled = 1'b1;

    // Single byte with push-latency check
    fork
      frame(8'hA5, 1'b1, 1'b0, 1'b1);
      begin
        int unsigned pe;
        @(posedge clk); #2;
        pe = push_edge(frame_a);
        while (ecnt < pe - 1) begin @(posedge clk); #1; end
        chk("irq_before_push", 32'(bus.rx_irq), 32'h0);
        @(posedge clk); #1;
        chk("irq_after_push", 32'(bus.rx_irq), 32'h1);
      end
    join
    do_read(A_DATA, 1, got);
    chk("read_a5", got, 32'h000000A5);

    // Long strobe pops only once
    frame(8'h11, 1'b1, 1'b0, 1'b1);
    frame(8'h22, 1'b1, 1'b0, 1'b1);
    do_read(A_DATA, 5, got);
    chk("hold_first", got, 32'h00000011);
    do_read(A_DATA, 1, got);
    chk("hold_second", got, 32'h00000022);

    // Overrun with five frames into a four-deep FIFO
    for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1, 1'b0, 1'b1);
    do_read(A_STAT, 1, got);
    chk("ovr_status", got, 32'h3);
    for (int i = 1; i <= 4; i++) begin
      do_read(A_DATA, 1, got);
      chk("ovr_order", got, 32'(i));
    end
    do_read(A_DATA, 1, got);
    chk("empty_read", got, 32'h0);
    do_read(A_STAT, 1, got);
    chk("stat_cleared", got, 32'h0);

    // Framing error followed by a held break
    frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (40 * P) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (2 * P) @(posedge clk);
    do_read(A_STAT, 1, got);
    chk("ferr_status", got, 32'h4);
    frame(8'h7E, 1'b1, 1'b0, 1'b1);
    do_read(A_DATA, 1, got);
    chk("after_break", got, 32'h0000007E);

    // False start: short low pulse
    bus.addr = A_OTHER;
    settled  = 1'b0;
    @(posedge clk); #1 rxd = 1'b0;
    repeat (4 * D) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (2 * P) @(posedge clk);
    settled = 1'b1;
    repeat (4) @(posedge clk);
    frame(8'h33, 1'b1, 1'b0, 1'b1);
    do_read(A_STAT, 1, got);
    chk("false_start_stat", got, 32'h1);
    do_read(A_DATA, 1, got);
    chk("false_start_next", got, 32'h00000033);

    // Push into full FIFO in the same cycle as a DATA pop
    for (int i = 0; i < 4; i++) frame(8'h41 + 8'(i), 1'b1, 1'b0, 1'b1);
    settled = 1'b0;
    fork
      send_frame(8'h45, 1'b1, 1'b0, 1'b1);
      begin
        int unsigned pe;
        @(posedge clk); #2;
        pe = push_edge(frame_a);
        while (ecnt < pe - 1) begin @(posedge clk); #1; end
        bus.addr = A_DATA;
        bus.re   = 1'b1;
        @(posedge clk);
        void'(q.pop_front());
        #1 bus.re = 1'b0;
      end
    join
    model_frame(8'h45, 1'b1, 1'b0);
    settled = 1'b1;
    do_read(A_STAT, 1, got);
    chk("same_clk_stat", got, 32'h1);
    for (int i = 0; i < 4; i++) begin
      do_read(A_DATA, 1, got);
      chk("same_clk_order", got, 32'h42 + 32'(i));
    end

`ifdef UART_RX_PARITY_EN
    // Bad parity drops the byte and sets perr
    frame(8'h07, 1'b1, 1'b1, 1'b1);
    do_read(A_STAT, 1, got);
    chk("perr_status", got, 32'h8);
`endif

    // Reset in the middle of a frame flushes everything
    frame(8'h66, 1'b1, 1'b0, 1'b1);
    settled = 1'b0;
    @(posedge clk); #1 rxd = 1'b0;
    repeat (3 * P) @(posedge clk);
    #1 rxd = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    bus.addr = A_STAT;
    repeat (3) @(negedge clk);
    chk("midreset_irq", 32'(bus.rx_irq), 32'h0);
    chk("midreset_stat", bus.rdata, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    settled = 1'b1;
    frame(8'h5A, 1'b1, 1'b0, 1'b1);
    do_read(A_DATA, 1, got);
    chk("after_reset", got, 32'h0000005A);

    repeat (4) @(posedge clk);
    settled = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
